// File: rtl/imdr_arb_pkg.sv
// Shared encodings for the integer mul/div/rem arbiter.
package imdr_arb_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_DIV = 2'b01,
    OP_REM = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_BUSY  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  localparam int TIMEOUT_LIMIT = 48;
  localparam int WD_W          = 6;
  // Counter value seen during the last BUSY cycle before the watchdog fires.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_LIMIT - 1);

  typedef struct packed {
    logic        id;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

endpackage

// File: rtl/imdr_arb_rr.sv
// Two-way round-robin grant; pointer remembers the last granted requester.
module imdr_arb_rr (
  input  logic clk,
  input  logic reset_l,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant
);

  logic last_q;

  always_comb begin
    if (valid0 && valid1) grant = ~last_q;
    else                  grant = ~valid0 & valid1;
  end

  // Reset to "req1 last" so req0 wins the first contention.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)     last_q <= 1'b1;
    else if (advance) last_q <= grant;
  end

endmodule

// File: rtl/imdr_arb.sv
// Arbiter between integer pipe (req0) and microcode sequencer (req1) for one mul/div unit.
// Optional BUSY watchdog enabled by defining IMDR_ARB_TIMEOUT_EN.
module imdr_arb
  import imdr_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  input  logic        kill0,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_div0,
  input  logic        rsp_ready,
  output logic        imdr_mul_d,
  output logic        imdr_div_d,
  output logic        imdr_rem_d,
  output logic [31:0] imdr_dataA_d,
  output logic [31:0] imdr_dataB_d,
  output logic        imdr_kill_e,
  input  logic        imdr_done_e,
  input  logic        imdr_div0_e,
  input  logic [31:0] imdr_data_out,
  output logic        timeout_err
);

  state_e      state_q, state_d;
  req_t        req_q;
  logic [31:0] data_q;
  logic        div0_q;
  logic        grant, acc0, acc1, accept;
  logic        kill_hit, done_hit, to_hit;

  imdr_arb_rr u_rr (
    .clk     (clk),
    .reset_l (reset_l),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;

  // kill0 only targets requester-0 work; it beats a same-cycle done.
  assign kill_hit = kill0 & ~req_q.id & (state_q != S_IDLE);
  assign done_hit = (state_q == S_BUSY) & imdr_done_e & ~kill_hit;

`ifdef IMDR_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_ISSUE)     wd_d = '0;
    else if (state_q == S_BUSY) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) wd_q <= '0;
    else          wd_q <= wd_d;
  end

  assign to_hit = (state_q == S_BUSY) & ~imdr_done_e & ~kill_hit & (wd_q == WD_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (kill_hit)                state_d = S_IDLE;
        else if (req_q.op == OP_RSV) state_d = S_RESP;
        else                         state_d = S_BUSY;
      end
      S_BUSY: begin
        if (kill_hit)              state_d = S_IDLE;
        else if (done_hit || to_hit) state_d = S_RESP;
      end
      S_RESP:  if (kill_hit || rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    imdr_mul_d  = 1'b0;
    imdr_div_d  = 1'b0;
    imdr_rem_d  = 1'b0;
    imdr_kill_e = 1'b0;
    rsp_valid   = 1'b0;
    timeout_err = to_hit;
    unique case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
      end
      S_ISSUE: begin
        imdr_mul_d  = ~kill_hit & (req_q.op == OP_MUL);
        imdr_div_d  = ~kill_hit & (req_q.op == OP_DIV);
        imdr_rem_d  = ~kill_hit & (req_q.op == OP_REM);
        imdr_kill_e = kill_hit;
      end
      S_BUSY:  imdr_kill_e = kill_hit | to_hit;
      S_RESP:  rsp_valid   = ~kill_hit;
      default: ;
    endcase
  end

  // Result is cleared on accept so reserved ops and timeouts report 0.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      req_q  <= '0;
      data_q <= '0;
      div0_q <= 1'b0;
    end else begin
      if (acc1) begin
        req_q  <= '{id: 1'b1, op: op_e'(req1_op), a: req1_a, b: req1_b};
        data_q <= '0;
        div0_q <= 1'b0;
      end else if (acc0) begin
        req_q  <= '{id: 1'b0, op: op_e'(req0_op), a: req0_a, b: req0_b};
        data_q <= '0;
        div0_q <= 1'b0;
      end else if (done_hit) begin
        data_q <= imdr_data_out;
        div0_q <= imdr_div0_e;
      end else if (to_hit) begin
        data_q <= '0;
        div0_q <= 1'b0;
      end
    end
  end

  assign rsp_id       = req_q.id;
  assign rsp_data     = data_q;
  assign rsp_div0     = div0_q;
  assign imdr_dataA_d = req_q.a;
  assign imdr_dataB_d = req_q.b;

endmodule
